// File: rtl/match_select.sv
// Scores disparity candidates (2*fg - g2sum) and tracks best / second-best per search;
// emits winning place, score, brightness and confidence margin when a search closes.
module match_select #(
    parameter int SCW  = 16,
    parameter int CNTW = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cand_valid,
    input  logic                  cand_last,
    input  logic [13:0]           g2sum,
    input  logic [10:0]           gsum,
    input  logic [13:0]           fg,
    input  logic [5:0]            place,
    input  logic                  abort,
    output logic                  res_valid,
    output logic [5:0]            best_place,
    output logic signed [SCW-1:0] best_score,
    output logic [10:0]           best_gsum,
    output logic [15:0]           conf,
    output logic [CNTW-1:0]       cand_cnt
);

    localparam logic signed [SCW-1:0] SCORE_MIN = {1'b1, {(SCW-1){1'b0}}};
    localparam logic [CNTW-1:0]       CNT_MAX   = {CNTW{1'b1}};
    localparam logic [CNTW-1:0]       CNT_ONE   = CNTW'(1);

    logic [SCW:0]            diff_s;
    logic signed [SCW-1:0]   score_s;

    logic                    s1_v_q, s1_v_d, s1_last_q, s1_last_d;
    logic signed [SCW-1:0]   s1_score_q, s1_score_d;
    logic [5:0]              s1_place_q, s1_place_d;
    logic [10:0]             s1_gsum_q, s1_gsum_d;

    logic                    empty_q, empty_d;
    logic signed [SCW-1:0]   best_s_q, best_s_d, second_s_q, second_s_d;
    logic [5:0]              best_p_q, best_p_d;
    logic [10:0]             best_g_q, best_g_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [SCW-1:0]          margin_s;

    logic                    res_valid_q, res_valid_d;
    logic [5:0]              res_place_q, res_place_d;
    logic signed [SCW-1:0]   res_score_q, res_score_d;
    logic [10:0]             res_gsum_q, res_gsum_d;
    logic [15:0]             res_conf_q, res_conf_d;
    logic [CNTW-1:0]         res_cnt_q, res_cnt_d;

    // Zero-extended score; the result range always fits in SCW signed bits.
    assign diff_s  = (SCW+1)'({fg, 1'b0}) - (SCW+1)'(g2sum);
    assign score_s = diff_s[SCW-1:0];

    // Stage S1 capture; an abort drops the incoming candidate.
    always_comb begin
        s1_v_d     = cand_valid & ~abort;
        s1_last_d  = s1_last_q;
        s1_score_d = s1_score_q;
        s1_place_d = s1_place_q;
        s1_gsum_d  = s1_gsum_q;
        if (cand_valid) begin
            s1_last_d  = cand_last;
            s1_score_d = score_s;
            s1_place_d = place;
            s1_gsum_d  = gsum;
        end else begin
            s1_last_d  = s1_last_q;
        end
    end

    // Search state update and result load from the updated values.
    always_comb begin
        empty_d     = empty_q;
        best_s_d    = best_s_q;
        best_p_d    = best_p_q;
        best_g_d    = best_g_q;
        second_s_d  = second_s_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_place_d = res_place_q;
        res_score_d = res_score_q;
        res_gsum_d  = res_gsum_q;
        res_conf_d  = res_conf_q;
        res_cnt_d   = res_cnt_q;
        margin_s    = '0;
        if (abort) begin
            empty_d = 1'b1;
        end else if (s1_v_q) begin
            if (empty_q) begin
                best_s_d   = s1_score_q;
                best_p_d   = s1_place_q;
                best_g_d   = s1_gsum_q;
                second_s_d = SCORE_MIN;
                cnt_d      = CNT_ONE;
                empty_d    = 1'b0;
            end else begin
                // Strict compares: ties keep the earlier place as winner.
                if (s1_score_q > best_s_q) begin
                    second_s_d = best_s_q;
                    best_s_d   = s1_score_q;
                    best_p_d   = s1_place_q;
                    best_g_d   = s1_gsum_q;
                end else if (s1_score_q > second_s_q) begin
                    second_s_d = s1_score_q;
                end else begin
                    second_s_d = second_s_q;
                end
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            end
            margin_s = best_s_d - second_s_d;
            if (s1_last_q) begin
                res_valid_d = 1'b1;
                res_place_d = best_p_d;
                res_score_d = best_s_d;
                res_gsum_d  = best_g_d;
                res_conf_d  = (cnt_d == CNT_ONE) ? 16'hFFFF : 16'(margin_s);
                res_cnt_d   = cnt_d;
                empty_d     = 1'b1;
            end else begin
                res_valid_d = 1'b0;
            end
        end else begin
            empty_d = empty_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_score_q  <= '0;
            s1_place_q  <= 6'd0;
            s1_gsum_q   <= 11'd0;
            empty_q     <= 1'b1;
            best_s_q    <= '0;
            best_p_q    <= 6'd0;
            best_g_q    <= 11'd0;
            second_s_q  <= SCORE_MIN;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_place_q <= 6'd0;
            res_score_q <= '0;
            res_gsum_q  <= 11'd0;
            res_conf_q  <= 16'd0;
            res_cnt_q   <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_last_q   <= s1_last_d;
            s1_score_q  <= s1_score_d;
            s1_place_q  <= s1_place_d;
            s1_gsum_q   <= s1_gsum_d;
            empty_q     <= empty_d;
            best_s_q    <= best_s_d;
            best_p_q    <= best_p_d;
            best_g_q    <= best_g_d;
            second_s_q  <= second_s_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_place_q <= res_place_d;
            res_score_q <= res_score_d;
            res_gsum_q  <= res_gsum_d;
            res_conf_q  <= res_conf_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign best_place = res_place_q;
    assign best_score = res_score_q;
    assign best_gsum  = res_gsum_q;
    assign conf       = res_conf_q;
    assign cand_cnt   = res_cnt_q;

endmodule

// File: tb/tb_match_select.sv
// Directed bench for match_select: list-based search model checked every cycle,
// plus literal expectations per scenario.
module tb_match_select;

    logic               clk = 1'b0;
    logic               rst_n, cand_valid, cand_last, abort;
    logic [13:0]        g2sum, fg;
    logic [10:0]        gsum;
    logic [5:0]         place;
    logic               res_valid;
    logic [5:0]         best_place;
    logic signed [15:0] best_score;
    logic [10:0]        best_gsum;
    logic [15:0]        conf;
    logic [5:0]         cand_cnt;

    always #5 clk = ~clk;

    match_select #(.SCW(16), .CNTW(6)) dut (
        .clk(clk), .rst_n(rst_n), .cand_valid(cand_valid), .cand_last(cand_last),
        .g2sum(g2sum), .gsum(gsum), .fg(fg), .place(place), .abort(abort),
        .res_valid(res_valid), .best_place(best_place), .best_score(best_score),
        .best_gsum(best_gsum), .conf(conf), .cand_cnt(cand_cnt)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: collect the search as lists, evaluate when it closes.
    int  q_score[$];
    int  q_place[$];
    int  q_gsum[$];
    bit  pend_v = 1'b0, pend_last = 1'b0;
    int  pend_score, pend_place, pend_gsum;
    bit  model_ready = 1'b0;
    int  exp_rv = 0, exp_place = 0, exp_score = 0, exp_gsum = 0, exp_conf = 0, exp_cnt = 0;

    task automatic evaluate_search();
        int bi;
        int sec;
        bi = 0;
        for (int i = 1; i < q_score.size(); i++)
            if (q_score[i] > q_score[bi]) bi = i;
        exp_place = q_place[bi];
        exp_score = q_score[bi];
        exp_gsum  = q_gsum[bi];
        exp_cnt   = (q_score.size() > 63) ? 63 : q_score.size();
        if (q_score.size() == 1) begin
            exp_conf = 65535;
        end else begin
            sec = -100000;
            for (int i = 0; i < q_score.size(); i++)
                if (i != bi && q_score[i] > sec) sec = q_score[i];
            exp_conf = (exp_score - sec) & 65535;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            q_score.delete(); q_place.delete(); q_gsum.delete();
            pend_v = 1'b0;
            exp_rv = 0; exp_place = 0; exp_score = 0; exp_gsum = 0; exp_conf = 0; exp_cnt = 0;
            model_ready = 1'b1;
        end else if (abort) begin
            q_score.delete(); q_place.delete(); q_gsum.delete();
            pend_v = 1'b0;
            exp_rv = 0;
        end else begin
            exp_rv = 0;
            if (pend_v) begin
                q_score.push_back(pend_score);
                q_place.push_back(pend_place);
                q_gsum.push_back(pend_gsum);
                if (pend_last) begin
                    evaluate_search();
                    exp_rv = 1;
                    q_score.delete(); q_place.delete(); q_gsum.delete();
                end
            end
            pend_v     = cand_valid;
            pend_last  = cand_last;
            pend_score = 2 * int'(fg) - int'(g2sum);
            pend_place = int'(place);
            pend_gsum  = int'(gsum);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ready) begin
            check("res_valid", int'(res_valid), exp_rv);
            check("best_place", int'(best_place), exp_place);
            check("best_score", int'(best_score), exp_score);
            check("best_gsum", int'(best_gsum), exp_gsum);
            check("conf", int'(conf), exp_conf);
            check("cand_cnt", int'(cand_cnt), exp_cnt);
        end
    end

    // Result log for the literal, scenario-level checks.
    int res_count = 0;
    int res_cyc_q[$];
    int res_score_q[$];
    int res_conf_q[$];
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            res_count++;
            res_cyc_q.push_back(cyc);
            res_score_q.push_back(int'(best_score));
            res_conf_q.push_back(int'(conf));
        end
    end

    int strobe_cyc = 0;

    task automatic send(input int f, input int g2, input int p, input bit last);
        cand_valid = 1'b1;
        cand_last  = last;
        fg         = 14'(f);
        g2sum      = 14'(g2);
        place      = 6'(p);
        gsum       = 11'(p * 3 + 1);
        strobe_cyc = cyc;
        @(posedge clk); #1;
        cand_valid = 1'b0;
        cand_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int rc, s_a, s_b;

    initial begin
        rst_n = 1'b0; cand_valid = 1'b0; cand_last = 1'b0; abort = 1'b0;
        fg = 14'd0; g2sum = 14'd0; gsum = 11'd0; place = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_best_score", int'(best_score), 0);
        check("rst_cand_cnt", int'(cand_cnt), 0);
        rst_n = 1'b1;
        idle(2);

        // Scores 50, 220, 200, 220: the later tie becomes second.
        rc = res_count;
        send(100, 150, 0, 1'b0);
        send(200, 180, 16, 1'b0);
        send(150, 100, 32, 1'b0);
        send(200, 180, 48, 1'b1);
        s_a = strobe_cyc;
        idle(4);
        check("s1_results", res_count - rc, 1);
        check("s1_latency", res_cyc_q[$] - s_a, 2);
        check("s1_place", int'(best_place), 16);
        check("s1_score", int'(best_score), 220);
        check("s1_gsum", int'(best_gsum), 49);
        check("s1_conf", int'(conf), 0);
        check("s1_cnt", int'(cand_cnt), 4);

        // Lone candidate at the negative extreme.
        send(0, 16383, 7, 1'b1);
        idle(4);
        check("lone_score", int'(best_score), -16383);
        check("lone_conf", int'(conf), 65535);
        check("lone_cnt", int'(cand_cnt), 1);

        // Back-to-back searches A={10,40}, B={70,5}.
        rc = res_count;
        send(5, 0, 1, 1'b0);
        send(20, 0, 2, 1'b1);
        s_a = strobe_cyc;
        send(35, 0, 3, 1'b0);
        send(3, 1, 4, 1'b1);
        s_b = strobe_cyc;
        idle(4);
        check("b2b_results", res_count - rc, 2);
        check("b2b_gap", res_cyc_q[$] - res_cyc_q[$-1], 2);
        check("b2b_a_latency", res_cyc_q[$-1] - s_a, 2);
        check("b2b_b_latency", res_cyc_q[$] - s_b, 2);
        check("b2b_a_score", res_score_q[$-1], 40);
        check("b2b_a_conf", res_conf_q[$-1], 30);
        check("b2b_b_score", int'(best_score), 70);
        check("b2b_b_place", int'(best_place), 3);
        check("b2b_b_conf", int'(conf), 65);
        check("b2b_b_cnt", int'(cand_cnt), 2);

        // Abort after two candidates, then a fresh three-candidate search.
        rc = res_count;
        send(50, 0, 10, 1'b0);
        send(150, 0, 11, 1'b0);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        send(10, 0, 20, 1'b0);
        send(30, 0, 21, 1'b0);
        send(15, 0, 22, 1'b1);
        idle(4);
        check("abort_results", res_count - rc, 1);
        check("abort_score", int'(best_score), 60);
        check("abort_place", int'(best_place), 21);
        check("abort_conf", int'(conf), 30);
        check("abort_cnt", int'(cand_cnt), 3);

        // Abort coinciding with a candidate drops it as well.
        rc = res_count;
        send(50, 0, 1, 1'b0);
        abort = 1'b1;
        send(100, 0, 2, 1'b0);
        abort = 1'b0;
        send(5, 0, 3, 1'b1);
        idle(4);
        check("abortv_results", res_count - rc, 1);
        check("abortv_score", int'(best_score), 10);
        check("abortv_cnt", int'(cand_cnt), 1);
        check("abortv_conf", int'(conf), 65535);

        // Counter saturation: 71 equal scores.
        for (int i = 0; i < 70; i++) send(0, 0, (i + 5) % 64, 1'b0);
        send(0, 0, 9, 1'b1);
        idle(4);
        check("sat_cnt", int'(cand_cnt), 63);
        check("sat_place", int'(best_place), 5);
        check("sat_conf", int'(conf), 0);
        check("sat_score", int'(best_score), 0);

        // Reset in the middle of a search.
        rc = res_count;
        send(50, 0, 1, 1'b0);
        send(60, 0, 2, 1'b0);
        rst_n = 1'b0;
        idle(1);
        check("mrst_place", int'(best_place), 0);
        check("mrst_score", int'(best_score), 0);
        check("mrst_gsum", int'(best_gsum), 0);
        check("mrst_conf", int'(conf), 0);
        check("mrst_cnt", int'(cand_cnt), 0);
        rst_n = 1'b1;
        idle(5);
        check("mrst_no_result", res_count - rc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
